bin_to_bcd_seq: RTL and testbench

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method. It is generalised in input width and digit count, and uses valid/ready handshakes on input and output. It feeds the watch display path: hour, minute and second counters and the future stopwatch and date fields go through it before the 7-segment decoders. It also flags results that do not fit in DIGITS digits and produces a leading-zero blanking mask.

---
 rtl/bcd_pkg.sv | 24 ++
 rtl/bin_to_bcd_seq_digit_adj.sv | 20 ++
 rtl/bin_to_bcd_seq.sv | 160 ++++++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// ----------------------------------------------------------------------------
// bcd_pkg
// Shared types and constants for the sequential binary-to-BCD converter.
//   bcd_state_t : converter FSM states (IDLE, SHIFT, DONE)
//   BCD_DIGIT_W : bits per BCD digit
//   ADD3_THRESH : digit value at or above which the double-dabble add-3 applies
//   cnt_w()     : width of a counter that must hold the value bin_w
// ----------------------------------------------------------------------------
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } bcd_state_t;

    localparam int BCD_DIGIT_W = 4;
    localparam int ADD3_THRESH = 5;

    function automatic int cnt_w(input int bin_w);
        return $clog2(bin_w + 1);
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_digit_adj.sv
// ----------------------------------------------------------------------------
// bcd_digit_adj
// Combinational double-dabble digit correction: a digit of 5 or more gets 3
// added so that the following left shift carries correctly into the next
// decimal digit.
//   digit_in  : current BCD digit
//   digit_out : corrected digit (4-bit result, wraps naturally)
// ----------------------------------------------------------------------------
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_in,
    output logic [BCD_DIGIT_W-1:0] digit_out
);

    assign digit_out = (digit_in >= BCD_DIGIT_W'(ADD3_THRESH))
                     ? digit_in + BCD_DIGIT_W'(3)
                     : digit_in;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// ----------------------------------------------------------------------------
// bin_to_bcd_seq
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per
// clock, with valid/ready handshakes on both sides. Results wider than DIGITS
// digits are reported through out_ovf (out_bcd then holds value mod
// 10^DIGITS); out_blank marks leading-zero digits for display blanking.
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready : input handshake, in_bin sampled on accept
//   in_bin            : unsigned binary value, BIN_W bits
//   out_valid/out_ready : output handshake, results held while stalled
//   out_bcd           : DIGITS BCD digits, digit 0 (units) in the low nibble
//   out_ovf           : value did not fit in DIGITS digits
//   out_blank         : bit k set when digit k is a leading zero (bit 0 never)
//   busy              : conversion in progress or result pending
// ----------------------------------------------------------------------------
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [BIN_W-1:0]                in_bin,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [BCD_DIGIT_W*DIGITS-1:0]   out_bcd,
    output logic                            out_ovf,
    output logic [DIGITS-1:0]               out_blank,
    output logic                            busy
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = cnt_w(BIN_W);
    // All upper digits of a zero result are blanked; the units digit never is.
    localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

    bcd_state_t         state_q, state_d;
    logic [BIN_W-1:0]   shreg_q, shreg_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   out_bcd_q, out_bcd_d;
    logic               out_ovf_q, out_ovf_d;
    logic [DIGITS-1:0]  out_blank_q, out_blank_d;

    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   shift_bcd;
    logic               shift_ovf;
    logic               accept;

    function automatic logic [DIGITS-1:0] blank_mask(input logic [BCD_W-1:0] bcd,
                                                     input logic             ovf);
        logic [DIGITS-1:0] mask;
        logic              all_zero;
        mask     = '0;
        all_zero = 1'b1;
        // Walk down from the top digit; a digit is blank while everything
        // above it (and itself) is zero.
        for (int k = DIGITS - 1; k >= 1; k--) begin
            all_zero = all_zero & (bcd[k*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
            mask[k]  = all_zero & ~ovf;
        end
        return mask;
    endfunction

    // Add-3 correction on every digit, applied before the shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_in  (bcd_q  [g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_out (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // One shift step: the shreg MSB enters the units digit, and the bit
    // leaving the top digit is the carry past 10^DIGITS.
    assign shift_bcd = {bcd_adj[BCD_W-2:0], shreg_q[BIN_W-1]};
    assign shift_ovf = ovf_q | bcd_adj[BCD_W-1];

    assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_bcd   = out_bcd_q;
    assign out_ovf   = out_ovf_q;
    assign out_blank = out_blank_q;

    always_comb begin
        // NOTE: every signal gets its hold value first, so no path through
        // the case leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        shreg_d     = shreg_q;
        bcd_d       = bcd_q;
        ovf_d       = ovf_q;
        cnt_d       = cnt_q;
        out_bcd_d   = out_bcd_q;
        out_ovf_d   = out_ovf_q;
        out_blank_d = out_blank_q;

        unique case (state_q)
            SHIFT: begin
                bcd_d   = shift_bcd;
                shreg_d = shreg_q << 1;
                ovf_d   = shift_ovf;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    // Last bit: capture the finished result into the output
                    // registers so it stays put while the sink stalls.
                    state_d     = DONE;
                    out_bcd_d   = shift_bcd;
                    out_ovf_d   = shift_ovf;
                    out_blank_d = blank_mask(shift_bcd, shift_ovf);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: ;
        endcase

        // Accepting overrides the DONE->IDLE step, giving back-to-back
        // conversions without an idle bubble.
        if (accept) begin
            state_d = SHIFT;
            shreg_d = in_bin;
            bcd_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = CNT_W'(BIN_W);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its _d value from before the edge, regardless of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            bcd_q       <= '0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            out_bcd_q   <= '0;
            out_ovf_q   <= 1'b0;
            out_blank_q <= BLANK_RST;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bcd_q       <= bcd_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
            out_bcd_q   <= out_bcd_d;
            out_ovf_q   <= out_ovf_d;
            out_blank_q <= out_blank_d;
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// ----------------------------------------------------------------------------
// tb_bin_to_bcd_seq
// Four converter instances (8b/2d, 8b/3d, 16b/5d, 16b/4d) share clock, reset,
// in_bin and out_ready. The driver pushes hand-computed expectations into a
// per-instance queue at accept time; a negedge monitor compares each new
// result (data, ovf, blank and accept-to-valid latency) and pops on the
// output handshake.
// ----------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

    localparam int N = 4;
    localparam int BW [N] = '{8, 8, 16, 16};
    localparam int DG [N] = '{2, 3, 5, 4};

    typedef struct {
        logic [39:0] bcd;
        logic        ovf;
        logic [9:0]  blank;
        int          acc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         out_ready;
    logic [15:0]  in_bin;
    logic [N-1:0] in_valid, iready, ovalid, ovf, busy;
    logic [39:0]  obcd   [N];
    logic [9:0]   oblank [N];

    logic [7:0]   bcd0;
    logic [11:0]  bcd1;
    logic [19:0]  bcd2;
    logic [15:0]  bcd3;
    logic [1:0]   bl0;
    logic [2:0]   bl1;
    logic [4:0]   bl2;
    logic [3:0]   bl3;

    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t sb [N][$];
    bit   shown [N];
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(iready[0]),
        .in_bin(in_bin[7:0]), .out_valid(ovalid[0]), .out_ready(out_ready),
        .out_bcd(bcd0), .out_ovf(ovf[0]), .out_blank(bl0), .busy(busy[0]));
    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(iready[1]),
        .in_bin(in_bin[7:0]), .out_valid(ovalid[1]), .out_ready(out_ready),
        .out_bcd(bcd1), .out_ovf(ovf[1]), .out_blank(bl1), .busy(busy[1]));
    bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(iready[2]),
        .in_bin(in_bin), .out_valid(ovalid[2]), .out_ready(out_ready),
        .out_bcd(bcd2), .out_ovf(ovf[2]), .out_blank(bl2), .busy(busy[2]));
    bin_to_bcd_seq #(.BIN_W(16), .DIGITS(4)) u3 (
        .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(iready[3]),
        .in_bin(in_bin), .out_valid(ovalid[3]), .out_ready(out_ready),
        .out_bcd(bcd3), .out_ovf(ovf[3]), .out_blank(bl3), .busy(busy[3]));

    assign obcd[0]   = {32'd0, bcd0};
    assign obcd[1]   = {28'd0, bcd1};
    assign obcd[2]   = {20'd0, bcd2};
    assign obcd[3]   = {24'd0, bcd3};
    assign oblank[0] = {8'd0, bl0};
    assign oblank[1] = {7'd0, bl1};
    assign oblank[2] = {5'd0, bl2};
    assign oblank[3] = {6'd0, bl3};

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at posedge+1. Presents v, waits (bounded) for in_ready, records
    // the expectation with its accept edge number, and returns after that edge.
    task automatic send(input int d, input logic [15:0] v, input logic [39:0] eb,
                        input logic eo, input logic [9:0] ebl);
        int   guard;
        exp_t e;
        guard       = 0;
        in_bin      = v;
        in_valid[d] = 1'b1;
        #1;
        while (!iready[d] && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!iready[d]) begin
            check($sformatf("dut%0d in_ready timeout", d), 40'(iready[d]), 40'(1));
            in_valid[d] = 1'b0;
            return;
        end
        e.bcd   = eb;
        e.ovf   = eo;
        e.blank = ebl;
        e.acc   = cyc + 1;
        sb[d].push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()) != 0 && guard < 500) begin
            @(posedge clk); #1;
            guard++;
        end
        check("drain outstanding results",
              40'(sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size()), 40'(0));
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (ovalid[i] && !shown[i]) begin
                shown[i] = 1'b1;
                if (sb[i].size() == 0) begin
                    check($sformatf("dut%0d unexpected result", i), 40'(1), 40'(0));
                end else begin
                    mon_e = sb[i][0];
                    check($sformatf("dut%0d latency", i), 40'(cyc - mon_e.acc), 40'(BW[i]));
                    check($sformatf("dut%0d out_bcd", i), obcd[i], mon_e.bcd);
                    check($sformatf("dut%0d out_ovf", i), 40'(ovf[i]), 40'(mon_e.ovf));
                    check($sformatf("dut%0d out_blank", i), 40'(oblank[i]), 40'(mon_e.blank));
                end
            end
            if (ovalid[i] && out_ready) begin
                if (sb[i].size() != 0) void'(sb[i].pop_front());
                shown[i] = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        rst       = 1'b1;
        in_valid  = '0;
        in_bin    = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reset state of every instance
        for (int i = 0; i < N; i++) begin
            check($sformatf("dut%0d rst out_valid", i), 40'(ovalid[i]), 40'(0));
            check($sformatf("dut%0d rst in_ready", i), 40'(iready[i]), 40'(1));
            check($sformatf("dut%0d rst busy", i), 40'(busy[i]), 40'(0));
            check($sformatf("dut%0d rst out_bcd", i), obcd[i], 40'(0));
            check($sformatf("dut%0d rst out_ovf", i), 40'(ovf[i]), 40'(0));
            check($sformatf("dut%0d rst out_blank", i), 40'(oblank[i]), 40'((1 << DG[i]) - 2));
        end
        rst = 1'b0;
        @(posedge clk); #1;

        // 8b/2d sweep 0..59, back to back
        for (int v = 0; v < 60; v++) begin
            send(0, 16'(v), 40'((v / 10) * 16 + (v % 10)), 1'b0, (v < 10) ? 10'b10 : 10'b00);
        end
        in_valid[0] = 1'b0;
        drain();

        // 8b/2d overflow boundaries
        send(0, 16'd100, 40'h00, 1'b1, 10'b00);
        send(0, 16'd255, 40'h55, 1'b1, 10'b00);
        send(0, 16'd99,  40'h99, 1'b0, 10'b00);
        in_valid[0] = 1'b0;
        drain();

        // 8b/3d
        send(1, 16'd255, 40'h255, 1'b0, 10'b000);
        send(1, 16'd0,   40'h000, 1'b0, 10'b110);
        send(1, 16'd40,  40'h040, 1'b0, 10'b100);
        send(1, 16'd7,   40'h007, 1'b0, 10'b110);
        in_valid[1] = 1'b0;
        drain();

        // Backpressure: 5 stalled cycles in DONE with in_valid high
        out_ready = 1'b0;
        send(0, 16'd33, 40'h33, 1'b0, 10'b00);
        in_valid[0] = 1'b0;
        guard = 0;
        while (!ovalid[0] && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("bp reached DONE", 40'(ovalid[0]), 40'(1));
        for (int k = 0; k < 5; k++) begin
            in_valid[0] = 1'b1;
            in_bin      = 16'(70 + k);
            #1;
            check("bp out_valid held", 40'(ovalid[0]), 40'(1));
            check("bp in_ready low", 40'(iready[0]), 40'(0));
            check("bp out_bcd stable", obcd[0], 40'h33);
            check("bp out_ovf stable", 40'(ovf[0]), 40'(0));
            check("bp out_blank stable", 40'(oblank[0]), 40'(0));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(0, 16'd45, 40'h45, 1'b0, 10'b00);
        in_valid[0] = 1'b0;
        drain();

        // Reset on the 3rd SHIFT cycle of 200, then a clean conversion
        in_bin      = 16'd200;
        in_valid[0] = 1'b1;
        #1;
        check("rst-test in_ready before accept", 40'(iready[0]), 40'(1));
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst-test busy in SHIFT", 40'(busy[0]), 40'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst-test out_valid", 40'(ovalid[0]), 40'(0));
        check("rst-test out_bcd", obcd[0], 40'(0));
        check("rst-test in_ready", 40'(iready[0]), 40'(1));
        check("rst-test busy", 40'(busy[0]), 40'(0));
        send(0, 16'd12, 40'h12, 1'b0, 10'b00);
        in_valid[0] = 1'b0;
        drain();

        // 16-bit widths
        send(2, 16'd65535, 40'h65535, 1'b0, 10'b00000);
        send(2, 16'd1234,  40'h01234, 1'b0, 10'b10000);
        in_valid[2] = 1'b0;
        send(3, 16'd10000, 40'h0000, 1'b1, 10'b0000);
        send(3, 16'd9999,  40'h9999, 1'b0, 10'b0000);
        send(3, 16'd65535, 40'h5535, 1'b1, 10'b0000);
        in_valid[3] = 1'b0;
        drain();

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
